neuron_update_scheduler: RTL

NEURON_UPDATE_SCHEDULER -- requirements
Module: neuron_update_scheduler

---
 rtl/neuron_pkg.sv | 17 +
 rtl/neuron_state_bank.sv | 70 +++++++
 rtl/neuron_update_scheduler.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/neuron_pkg.sv
// Shared types and constants for the neuron update scheduler.
package neuron_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONFIG,
        S_LOAD,
        S_WAIT,
        S_CAPTURE,
        S_FINISH
    } state_e;

    localparam logic [31:0] FP32_ZERO         = 32'h0000_0000;
    localparam int          DEF_NUM_NEURONS   = 20;
    localparam int          DEF_ADDER_LATENCY = 2;

endpackage

// File: rtl/neuron_state_bank.sv
// Per-neuron weight and potential registers. A capture from the adder
// takes priority over an external weight write; the scheduler only lets
// external writes through while idle, so the two never actually collide.
module neuron_state_bank
    import neuron_pkg::*;
#(
    parameter int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int IDX_W       = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ext_wr_en_i,
    input  logic [IDX_W-1:0] ext_wr_idx_i,
    input  logic [31:0]      ext_wr_data_i,
    input  logic             cap_en_i,
    input  logic [IDX_W-1:0] cap_idx_i,
    input  logic [31:0]      cap_pot_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [31:0]      rd_weight_o,
    output logic [31:0]      rd_pot_o
);

    logic [31:0] weight_q [NUM_NEURONS];
    logic [31:0] weight_d [NUM_NEURONS];
    logic [31:0] pot_q    [NUM_NEURONS];
    logic [31:0] pot_d    [NUM_NEURONS];

    // Next-state of the arrays: capture clears the weight and stores the result;
    // out-of-range write indices match no entry and are dropped.
    always_comb begin
        weight_d = weight_q;
        pot_d    = pot_q;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (cap_en_i && (cap_idx_i == IDX_W'(i))) begin
                weight_d[i] = FP32_ZERO;
                pot_d[i]    = cap_pot_i;
            end else if (ext_wr_en_i && (ext_wr_idx_i == IDX_W'(i))) begin
                weight_d[i] = ext_wr_data_i;
            end
        end
    end

    // Array registers, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                weight_q[i] <= FP32_ZERO;
                pot_q[i]    <= FP32_ZERO;
            end
        end else begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                weight_q[i] <= weight_d[i];
                pot_q[i]    <= pot_d[i];
            end
        end
    end

    // Read mux for the neuron currently being scheduled.
    always_comb begin
        rd_weight_o = FP32_ZERO;
        rd_pot_o    = FP32_ZERO;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (rd_idx_i == IDX_W'(i)) begin
                rd_weight_o = weight_q[i];
                rd_pot_o    = pot_q[i];
            end
        end
    end

endmodule

// File: rtl/neuron_update_scheduler.sv
// Sweeps all neurons through one shared external potential adder per timestep.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no sweep; adder held in clear, weight writes accepted
// CONFIG   | one cycle of adder_set, neuron index reset to 0
// LOAD     | operands of neuron idx driven, latency counter loaded
// WAIT     | operands held while the adder settles
// CAPTURE  | result/spike of neuron idx captured on entry
// FINISH   | sweep over; done follows in the next cycle with busy low
module neuron_update_scheduler
    import neuron_pkg::*;
#(
    parameter int NUM_NEURONS   = DEF_NUM_NEURONS,
    parameter int IDX_W         = 5,
    parameter int ADDER_LATENCY = DEF_ADDER_LATENCY
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    input  logic                   w_wr_en,
    input  logic [IDX_W-1:0]       w_wr_idx,
    input  logic [31:0]            w_wr_data,
    output logic                   w_wr_ready,
    output logic                   adder_set,
    output logic                   adder_clear,
    output logic [31:0]            adder_weight,
    output logic [31:0]            adder_potential,
    input  logic [31:0]            adder_result,
    input  logic                   adder_spike,
    output logic                   spike_valid,
    output logic [IDX_W-1:0]       spike_idx,
    output logic [NUM_NEURONS-1:0] spike_vector
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_NEURONS - 1);
    localparam logic [3:0]       WAIT_INIT = 4'(ADDER_LATENCY - 1);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   spike_valid_q, spike_valid_d;
    logic [IDX_W-1:0]       spike_idx_q, spike_idx_d;
    logic [NUM_NEURONS-1:0] spike_vec_q, spike_vec_d;
    logic [31:0]            hold_w_q, hold_w_d;
    logic [31:0]            hold_p_q, hold_p_d;
    logic                   cap_en;
    logic [31:0]            rd_weight, rd_pot;

    neuron_state_bank #(
        .NUM_NEURONS (NUM_NEURONS),
        .IDX_W       (IDX_W)
    ) u_bank (
        .clk           (clk),
        .rst_n         (rst_n),
        .ext_wr_en_i   (w_wr_en && !busy_q),
        .ext_wr_idx_i  (w_wr_idx),
        .ext_wr_data_i (w_wr_data),
        .cap_en_i      (cap_en),
        .cap_idx_i     (idx_q),
        .cap_pot_i     (adder_result),
        .rd_idx_i      (idx_q),
        .rd_weight_o   (rd_weight),
        .rd_pot_o      (rd_pot)
    );

    // Next-state logic; capture fires on the transition into CAPTURE so the
    // adder result is sampled exactly ADDER_LATENCY cycles after LOAD.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        busy_d        = busy_q;
        spike_vec_d   = spike_vec_q;
        hold_w_d      = hold_w_q;
        hold_p_d      = hold_p_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_CONFIG;
                    busy_d      = 1'b1;
                    spike_vec_d = '0;
                end
            end
            S_CONFIG: begin
                idx_d   = '0;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                cnt_d    = WAIT_INIT;
                hold_w_d = rd_weight;
                hold_p_d = rd_pot;
                state_d  = (WAIT_INIT == 4'd0) ? S_CAPTURE : S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_FINISH;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_FINISH: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        cap_en        = (state_d == S_CAPTURE) && (state_q != S_CAPTURE);
        spike_valid_d = cap_en && adder_spike;
        spike_idx_d   = cap_en ? idx_q : spike_idx_q;
        done_d        = (state_q == S_FINISH);
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (cap_en && (idx_q == IDX_W'(i))) spike_vec_d[i] = adder_spike;
        end
    end

    // Control and operand-hold registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            spike_valid_q <= 1'b0;
            spike_idx_q   <= '0;
            spike_vec_q   <= '0;
            hold_w_q      <= FP32_ZERO;
            hold_p_q      <= FP32_ZERO;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            spike_valid_q <= spike_valid_d;
            spike_idx_q   <= spike_idx_d;
            spike_vec_q   <= spike_vec_d;
            hold_w_q      <= hold_w_d;
            hold_p_q      <= hold_p_d;
        end
    end

    // Adder drive: live bank read in LOAD, held copy through WAIT and CAPTURE
    // (the bank entry is overwritten on CAPTURE entry), zero otherwise.
    always_comb begin
        adder_set       = (state_q == S_CONFIG);
        adder_clear     = (state_q == S_IDLE) || (state_q == S_FINISH);
        adder_weight    = FP32_ZERO;
        adder_potential = FP32_ZERO;
        if (state_q == S_LOAD) begin
            adder_weight    = rd_weight;
            adder_potential = rd_pot;
        end else if ((state_q == S_WAIT) || (state_q == S_CAPTURE)) begin
            adder_weight    = hold_w_q;
            adder_potential = hold_p_q;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign w_wr_ready   = !busy_q;
    assign spike_valid  = spike_valid_q;
    assign spike_idx    = spike_idx_q;
    assign spike_vector = spike_vec_q;

endmodule
